// File: rtl/mult_add_clip_unit.sv
// Pipelined signed fixed-point O = saturate(A*B + C) with independent binary points and LATENCY 1..4.
// Optional MULT_ADD_CLIP_ROUND_EN switches the output quantiser from floor to round-half-up.
module mult_add_clip_unit #(
  parameter int WIDTH_A  = 18,
  parameter int BIN_PT_A = 17,
  parameter int WIDTH_B  = 18,
  parameter int BIN_PT_B = 17,
  parameter int WIDTH_C  = 24,
  parameter int BIN_PT_C = 23,
  parameter int WIDTH_O  = 24,
  parameter int BIN_PT_O = 23,
  parameter int LATENCY  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CE,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic [WIDTH_C-1:0] C,
  output logic [WIDTH_O-1:0] O
);

  localparam int WP   = WIDTH_A + WIDTH_B;
  localparam int BP_P = BIN_PT_A + BIN_PT_B;
  localparam int FP0  = (BP_P > BIN_PT_C) ? BP_P : BIN_PT_C;
  localparam int FP   = (FP0 > BIN_PT_O) ? FP0 : BIN_PT_O;
  localparam int IP_P = WP - BP_P;
  localparam int IP_C = WIDTH_C - BIN_PT_C;
  // One guard integer bit above the wider operand keeps P + C exact.
  localparam int IP   = ((IP_P > IP_C) ? IP_P : IP_C) + 1;
  localparam int WS   = IP + FP;
  localparam int SH_P = FP - BP_P;
  localparam int SH_C = FP - BIN_PT_C;
  localparam int SH_O = FP - BIN_PT_O;
  localparam int WE   = WS + 1;
  localparam int WQ   = WE - SH_O;
  localparam int WQX  = ((WQ > WIDTH_O) ? WQ : WIDTH_O) + 1;

`ifdef MULT_ADD_CLIP_ROUND_EN
  localparam int RND_SH = (SH_O > 0) ? SH_O - 1 : 0;
  localparam logic signed [WE-1:0] HALF_LSB = (SH_O > 0) ? (WE'(1) <<< RND_SH) : '0;
`endif

  function automatic logic signed [WP-1:0] mul(input logic [WIDTH_A-1:0] a,
                                               input logic [WIDTH_B-1:0] b);
    return WP'($signed(a)) * WP'($signed(b));
  endfunction

  function automatic logic signed [WS-1:0] align_sum(input logic signed [WP-1:0] p,
                                                     input logic signed [WIDTH_C-1:0] c);
    logic signed [WS-1:0] p_ext;
    logic signed [WS-1:0] c_ext;
    p_ext = WS'(p) <<< SH_P;
    c_ext = WS'(c) <<< SH_C;
    return p_ext + c_ext;
  endfunction

  // Extra top bit absorbs the rounding increment; saturation checks that all bits
  // from the output sign bit upward agree.
  function automatic logic [WIDTH_O-1:0] quant_clip(input logic signed [WS-1:0] s);
    logic signed [WE-1:0]     s_ext;
    logic signed [WE-1:0]     s_shr;
    logic signed [WQX-1:0]    q;
    logic [WQX-WIDTH_O:0]     top;
    s_ext = WE'(s);
`ifdef MULT_ADD_CLIP_ROUND_EN
    s_ext = s_ext + HALF_LSB;
`endif
    s_shr = s_ext >>> SH_O;
    q     = WQX'(s_shr);
    top   = q[WQX-1:WIDTH_O-1];
    if ((&top) || !(|top))
      return q[WIDTH_O-1:0];
    else if (q[WQX-1])
      return {1'b1, {(WIDTH_O-1){1'b0}}};
    else
      return {1'b0, {(WIDTH_O-1){1'b1}}};
  endfunction

  logic [WIDTH_O-1:0] o_d;
  logic [WIDTH_O-1:0] o_q;

  generate
    if (BIN_PT_A < 0 || BIN_PT_B < 0 || BIN_PT_C < 0 || BIN_PT_O < 0) begin : g_bad_point
      $error("mult_add_clip_unit: binary points must be non-negative");
    end

    case (LATENCY)
      1: begin : g_lat1
        always_comb o_d = quant_clip(align_sum(mul(A, B), $signed(C)));
      end

      2: begin : g_lat2
        logic signed [WP-1:0]      p_q;
        logic signed [WIDTH_C-1:0] c_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            p_q <= '0;
            c_q <= '0;
          end else if (CE) begin
            p_q <= mul(A, B);
            c_q <= $signed(C);
          end
        end
        always_comb o_d = quant_clip(align_sum(p_q, c_q));
      end

      3: begin : g_lat3
        logic [WIDTH_A-1:0]        a_q;
        logic [WIDTH_B-1:0]        b_q;
        logic signed [WIDTH_C-1:0] c_q;
        logic signed [WP-1:0]      p_q;
        logic signed [WIDTH_C-1:0] c2_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            p_q  <= '0;
            c2_q <= '0;
          end else if (CE) begin
            a_q  <= A;
            b_q  <= B;
            c_q  <= $signed(C);
            p_q  <= mul(a_q, b_q);
            c2_q <= c_q;
          end
        end
        always_comb o_d = quant_clip(align_sum(p_q, c2_q));
      end

      4: begin : g_lat4
        logic [WIDTH_A-1:0]        a_q;
        logic [WIDTH_B-1:0]        b_q;
        logic signed [WIDTH_C-1:0] c_q;
        logic signed [WP-1:0]      p_q;
        logic signed [WIDTH_C-1:0] c2_q;
        logic signed [WS-1:0]      s_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            p_q  <= '0;
            c2_q <= '0;
            s_q  <= '0;
          end else if (CE) begin
            a_q  <= A;
            b_q  <= B;
            c_q  <= $signed(C);
            p_q  <= mul(a_q, b_q);
            c2_q <= c_q;
            s_q  <= align_sum(p_q, c2_q);
          end
        end
        always_comb o_d = quant_clip(s_q);
      end

      default: begin : g_bad_latency
        $error("mult_add_clip_unit: LATENCY must be in 1..4");
        always_comb o_d = '0;
      end
    endcase
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      o_q <= '0;
    else if (CE)
      o_q <= o_d;
  end

  assign O = o_q;

endmodule

// File: tb/tb_mult_add_clip_unit.sv
// Randomised + directed bench for mult_add_clip_unit, RX and TX widths at every LATENCY 1..4.
module tb_mult_add_clip_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [17:0] a_rx, b_rx, b_tx;
  logic [23:0] c_rx;
  logic [15:0] a_tx, c_tx;
  logic [23:0] o_rx [1:4];
  logic [23:0] o_tx [1:4];

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [23:0] hist_rx [$];
  logic [23:0] hist_tx [$];

  localparam logic [17:0] DV_A [6] = '{18'h04444, 18'h0CCCC, 18'h04444, 18'h0CCCC, 18'h20000, 18'h1FFFF};
  localparam logic [17:0] DV_B [6] = '{18'h10000, 18'h3FFFF, 18'h3FFFF, 18'h10000, 18'h1FFFF, 18'h1FFFF};
  localparam logic [23:0] DV_C [6] = '{24'h000000, 24'h000000, 24'h101010, 24'hFFFFF1, 24'h880000, 24'h70FFFF};
  localparam logic [23:0] DV_O [6] = '{24'h088880, 24'hFFFFE6, 24'h101007, 24'h199971, 24'h800000, 24'h7FFFFF};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 1; gi <= 4; gi++) begin : g_lat
      mult_add_clip_unit #(.LATENCY(gi)) u_rx (
        .clk(clk), .reset(reset), .CE(ce), .A(a_rx), .B(b_rx), .C(c_rx), .O(o_rx[gi])
      );
      mult_add_clip_unit #(.WIDTH_A(16), .BIN_PT_A(15), .WIDTH_C(16), .BIN_PT_C(15),
                           .LATENCY(gi)) u_tx (
        .clk(clk), .reset(reset), .CE(ce), .A(a_tx), .B(b_tx), .C(c_tx), .O(o_tx[gi])
      );
    end
  endgenerate

  // Reference: exact product and addend on a common grid, floor to Q.23, clamp to 24 bits.
  function automatic logic [23:0] ref_mac(input longint a, input longint b, input longint c,
                                          input int bpp, input int bpc);
    int fp;
    longint s, q;
    logic [63:0] qb;
    fp = (bpp > bpc) ? bpp : bpc;
    if (fp < 23) fp = 23;
    s = ((a * b) <<< (fp - bpp)) + (c <<< (fp - bpc));
    q = s >>> (fp - 23);
    if (q > 64'sd8388607) q = 64'sd8388607;
    else if (q < -64'sd8388608) q = -64'sd8388608;
    qb = q;
    return qb[23:0];
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(0, 5))
      0:       return (one << (w - 1)) - 1;
      1:       return one << (w - 1);
      2:       return '1;
      3:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [23:0] er, et;
    for (int l = 1; l <= 4; l++) begin
      er = (hist_rx.size() >= l) ? hist_rx[hist_rx.size() - l] : 24'h0;
      et = (hist_tx.size() >= l) ? hist_tx[hist_tx.size() - l] : 24'h0;
      check_val($sformatf("rx_lat%0d", l), o_rx[l], er);
      check_val($sformatf("tx_lat%0d", l), o_tx[l], et);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int l = 1; l <= 4; l++) begin
      check_val($sformatf("%s_rx_lat%0d", tag, l), o_rx[l], 24'h0);
      check_val($sformatf("%s_tx_lat%0d", tag, l), o_tx[l], 24'h0);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge sample, then check at the next falling edge.
  task automatic cycle(input logic ce_v,
                       input logic [17:0] ar, input logic [17:0] br, input logic [23:0] cr,
                       input logic [15:0] at, input logic [17:0] bt, input logic [15:0] ct,
                       input logic gr_v, input logic [23:0] gr,
                       input logic gt_v, input logic [23:0] gt);
    ce = ce_v; a_rx = ar; b_rx = br; c_rx = cr; a_tx = at; b_tx = bt; c_tx = ct;
    @(posedge clk);
    if (ce_v) begin
      hist_rx.push_back(gr_v ? gr : ref_mac(longint'($signed(ar)), longint'($signed(br)),
                                            longint'($signed(cr)), 34, 23));
      hist_tx.push_back(gt_v ? gt : ref_mac(longint'($signed(at)), longint'($signed(bt)),
                                            longint'($signed(ct)), 32, 15));
    end
    @(negedge clk);
    check_outputs();
    $display("txn %0d ce=%0b rx A=%h B=%h C=%h tx A=%h B=%h C=%h", txn, ce_v, ar, br, cr, at, bt, ct);
    txn++;
  endtask

  task automatic rand_cycle(input logic ce_v);
    logic [31:0] t1, t2, t3, t4, t5, t6;
    t1 = pick(18); t2 = pick(18); t3 = pick(24);
    t4 = pick(16); t5 = pick(18); t6 = pick(16);
    cycle(ce_v, t1[17:0], t2[17:0], t3[23:0], t4[15:0], t5[17:0], t6[15:0],
          1'b0, 24'h0, 1'b0, 24'h0);
  endtask

  task automatic directed_burst();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)
        cycle(1'b1, DV_A[i], DV_B[i], DV_C[i], 16'h1111, 18'h3FFFF, 16'h1010,
              1'b1, DV_O[i], 1'b1, 24'h100FF7);
      else
        cycle(1'b1, DV_A[i], DV_B[i], DV_C[i], 16'($urandom), 18'($urandom), 16'($urandom),
              1'b1, DV_O[i], 1'b0, 24'h0);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0;
    a_rx = '0; b_rx = '0; c_rx = '0; a_tx = '0; b_tx = '0; c_tx = '0;
    #1 reset = 1'b0;
    @(negedge clk);

    // Held in reset with random inputs and CE: every output stays zero.
    for (int i = 0; i < 6; i++) begin
      ce = 1'($urandom_range(0, 1));
      a_rx = 18'($urandom); b_rx = 18'($urandom); c_rx = 24'($urandom);
      a_tx = 16'($urandom); b_tx = 18'($urandom); c_tx = 16'($urandom);
      @(negedge clk);
      check_zero("rst");
      $display("txn %0d reset held ce=%0b", txn, ce);
      txn++;
    end
    reset = 1'b1;

    directed_burst();
    for (int i = 0; i < 200; i++) rand_cycle($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-stream, between clock edges.
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    $display("txn %0d async reset", txn);
    txn++;
    hist_rx.delete();
    hist_tx.delete();
    @(negedge clk);
    reset = 1'b1;

    directed_burst();
    for (int i = 0; i < 12; i++) rand_cycle(1'b1);
    for (int i = 0; i < 4; i++) rand_cycle(1'b0);
    for (int i = 0; i < 6; i++) rand_cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
